// File: rtl/conv_stim_source_pkg.sv
// Shared types and constants for the conv_8_4 stimulus source.
// Holds the sample type, the FSM state encoding and the load-select codes.
package conv_stim_source_pkg;

    localparam int WIDTH = 8;
    localparam int NX    = 8;
    localparam int NF    = 4;
    localparam int LOGX  = 3;
    localparam int LOGF  = 2;
    localparam int RUNW  = 4;

    typedef logic signed [WIDTH-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_F = 1'b1;

endpackage

// File: rtl/conv_stim_source_if.sv
// Valid/ready stream bundle carrying the x and f channels towards conv_8_4.
// The source drives through master; the sink (conv_8_4 or a bench) uses slave.
interface conv_stim_source_if;
    import conv_stim_source_pkg::*;

    sample_t m_data_x;
    logic    m_valid_x;
    logic    m_ready_x;
    sample_t m_data_f;
    logic    m_valid_f;
    logic    m_ready_f;

    modport master (
        output m_data_x, m_valid_x,
        input  m_ready_x,
        output m_data_f, m_valid_f,
        input  m_ready_f
    );

    modport slave (
        input  m_data_x, m_valid_x,
        output m_ready_x,
        input  m_data_f, m_valid_f,
        output m_ready_f
    );

endinterface

// File: rtl/conv_stim_source_stream_chan.sv
// One stream channel: a small register array replayed over valid/ready,
// repeated for the requested number of runs, with a completion flag.
module stream_chan
    import conv_stim_source_pkg::*;
#(
    parameter int DEPTH = NX,
    parameter int LOGD  = LOGX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [LOGD-1:0]  wr_addr,
    input  sample_t          wr_data,
    input  logic             clear,
    input  logic             go,
    input  logic [RUNW-1:0]  runs,
    input  logic             ready,
    output logic             valid,
    output sample_t          data,
    output logic             finishing,
    output logic             complete
);

    localparam logic [LOGD-1:0] LAST = LOGD'(DEPTH - 1);

    sample_t         arr_q [DEPTH];
    logic [LOGD-1:0] idx_q;
    logic [RUNW-1:0] run_q;
    logic [RUNW-1:0] run_inc;
    logic            fire;
    logic            wrap;

    assign fire      = valid && ready;
    assign wrap      = (idx_q == LAST);
    assign run_inc   = run_q + RUNW'(1);
    // The beat that closes the last run; lets the top leave SEND on this same edge.
    assign finishing = fire && wrap && (run_inc == runs);
    assign data      = arr_q[idx_q];

    // NOTE: non-blocking assignments for all state here, so every register
    // samples its inputs as they stood before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the sample arrays are reset explicitly; a post-reset stream
            // must emit zeros rather than whatever the flops powered up with.
            for (int i = 0; i < DEPTH; i++) arr_q[i] <= '0;
            idx_q    <= '0;
            run_q    <= '0;
            valid    <= 1'b0;
            complete <= 1'b0;
        end else begin
            if (wr_en) arr_q[wr_addr] <= wr_data;

            if (clear) begin
                idx_q    <= '0;
                run_q    <= '0;
                valid    <= go;
                complete <= 1'b0;
            end else if (fire) begin
                if (wrap) begin
                    idx_q <= '0;
                    run_q <= run_inc;
                    if (run_inc == runs) begin
                        valid    <= 1'b0;
                        complete <= 1'b1;
                    end
                end else begin
                    idx_q <= idx_q + LOGD'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_stim_source.sv
// Stimulus source for conv_8_4: host loads x/f vectors while idle, then a
// start streams both vectors num_runs times over independent channels.
module conv_stim_source
    import conv_stim_source_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_en,
    input  logic            ld_sel,
    input  logic [LOGX-1:0] ld_addr,
    input  sample_t         ld_data,
    input  logic            start,
    input  logic [RUNW-1:0] num_runs,
    output logic            busy,
    output logic            done,
    conv_stim_source_if.master bus
);

    state_t          state_q;
    state_t          state_d;
    logic            done_d;
    logic            start_ok;
    logic            load_ok;
    logic            go;
    logic [RUNW-1:0] runs_left_q;
    logic            x_finishing;
    logic            x_complete;
    logic            f_finishing;
    logic            f_complete;

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        start_ok = 1'b0;
        load_ok  = 1'b0;
        case (state_q)
            IDLE: begin
                load_ok = ld_en;
                if (start) begin
                    start_ok = 1'b1;
                    if (num_runs == '0) done_d  = 1'b1;
                    else                state_d = SEND;
                end
            end
            SEND: begin
                if ((x_complete || x_finishing) && (f_complete || f_finishing)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            done        <= 1'b0;
            runs_left_q <= '0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            if (start_ok) runs_left_q <= num_runs;
        end
    end

    assign busy = (state_q == SEND);
    assign go   = start_ok && (num_runs != '0);

    stream_chan #(.DEPTH(NX), .LOGD(LOGX)) u_chan_x (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (load_ok && (ld_sel == SEL_X)),
        .wr_addr   (ld_addr),
        .wr_data   (ld_data),
        .clear     (start_ok),
        .go        (go),
        .runs      (runs_left_q),
        .ready     (bus.m_ready_x),
        .valid     (bus.m_valid_x),
        .data      (bus.m_data_x),
        .finishing (x_finishing),
        .complete  (x_complete)
    );

    stream_chan #(.DEPTH(NF), .LOGD(LOGF)) u_chan_f (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (load_ok && (ld_sel == SEL_F)),
        .wr_addr   (ld_addr[LOGF-1:0]),
        .wr_data   (ld_data),
        .clear     (start_ok),
        .go        (go),
        .runs      (runs_left_q),
        .ready     (bus.m_ready_f),
        .valid     (bus.m_valid_f),
        .data      (bus.m_data_f),
        .finishing (f_finishing),
        .complete  (f_complete)
    );

endmodule

// File: tb/tb_conv_stim_source.sv
// Randomised bench for conv_stim_source: a queue-based model of the expected
// beat sequences is compared against both channels cycle by cycle.
module tb_conv_stim_source;
    import conv_stim_source_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            ld_en;
    logic            ld_sel;
    logic [LOGX-1:0] ld_addr;
    sample_t         ld_data;
    logic            start;
    logic [RUNW-1:0] num_runs;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    sample_t mx [NX];
    sample_t mf [NF];

    conv_stim_source_if bus ();

    conv_stim_source dut (
        .clk      (clk),
        .reset    (reset),
        .ld_en    (ld_en),
        .ld_sel   (ld_sel),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .num_runs (num_runs),
        .busy     (busy),
        .done     (done),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic sel, input int addr, input int val);
        @(posedge clk); #1;
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = LOGX'(addr);
        ld_data = sample_t'(val);
        if (sel == SEL_X) mx[addr] = sample_t'(val);
        else              mf[addr] = sample_t'(val);
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Start a transfer and follow it until the done pulse. inject_at >= 0
    // pulses start+ld_en (x[0]=99) during SEND, which must be ignored.
    task automatic run_stream(input int runs, input int pct, input int inject_at,
                              input bit ld_first, input int ld_val);
        sample_t exp_x[$];
        sample_t exp_f[$];
        bit      finished  = 0;
        bit      completed = 0;
        bit      px_stall  = 0;
        bit      pf_stall  = 0;
        int      px_data   = 0;
        int      pf_data   = 0;
        int      x_last    = -1;
        int      f_last    = -1;

        @(posedge clk); #1;
        start    = 1'b1;
        num_runs = RUNW'(runs);
        if (ld_first) begin
            ld_en   = 1'b1;
            ld_sel  = SEL_X;
            ld_addr = '0;
            ld_data = sample_t'(ld_val);
            mx[0]   = sample_t'(ld_val);
        end
        for (int r = 0; r < runs; r++) begin
            for (int i = 0; i < NX; i++) exp_x.push_back(mx[i]);
            for (int i = 0; i < NF; i++) exp_f.push_back(mf[i]);
        end
        @(posedge clk); #1;
        start = 1'b0;
        ld_en = 1'b0;

        if (runs == 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("zero_done", int'(done), (k == 0) ? 1 : 0);
                check("zero_busy", int'(busy), 0);
                check("zero_valid", int'({bus.m_valid_x, bus.m_valid_f}), 0);
                @(posedge clk); #1;
            end
            return;
        end

        for (int c = 0; c < 400 && !completed; c++) begin
            if (c == inject_at) begin
                start    = 1'b1;
                num_runs = RUNW'(3);
                ld_en    = 1'b1;
                ld_sel   = SEL_X;
                ld_addr  = '0;
                ld_data  = sample_t'(99);
            end else begin
                start = 1'b0;
                ld_en = 1'b0;
            end
            bus.m_ready_x = ($urandom_range(99) < pct);
            bus.m_ready_f = ($urandom_range(99) < pct);
            @(negedge clk);
            if (finished) begin
                check("done_pulse", int'(done), 1);
                check("done_busy", int'(busy), 0);
                check("done_valid", int'({bus.m_valid_x, bus.m_valid_f}), 0);
                completed = 1;
            end else begin
                if (c == 0) check("valid_rise", int'({bus.m_valid_x, bus.m_valid_f, busy}), 7);
                check("early_done", int'(done), 0);

                if (px_stall) begin
                    check("x_hold_valid", int'(bus.m_valid_x), 1);
                    check("x_hold_data", int'(bus.m_data_x), px_data);
                end
                if (bus.m_valid_x && bus.m_ready_x) begin
                    if (exp_x.size() == 0) check("x_extra_beat", 1, 0);
                    else begin
                        check("x_data", int'(bus.m_data_x), int'(exp_x.pop_front()));
                        x_last = c;
                    end
                end
                px_stall = bus.m_valid_x && !bus.m_ready_x;
                px_data  = int'(bus.m_data_x);

                if (pf_stall) begin
                    check("f_hold_valid", int'(bus.m_valid_f), 1);
                    check("f_hold_data", int'(bus.m_data_f), pf_data);
                end
                if (bus.m_valid_f && bus.m_ready_f) begin
                    if (exp_f.size() == 0) check("f_extra_beat", 1, 0);
                    else begin
                        check("f_data", int'(bus.m_data_f), int'(exp_f.pop_front()));
                        f_last = c;
                    end
                end
                pf_stall = bus.m_valid_f && !bus.m_ready_f;
                pf_data  = int'(bus.m_data_f);

                if (exp_x.size() == 0 && exp_f.size() == 0) finished = 1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        ld_en = 1'b0;

        if (!completed) check("stream_timeout", 0, 1);
        if (pct >= 100) begin
            check("x_back2back", x_last, NX * runs - 1);
            check("f_back2back", f_last, NF * runs - 1);
        end
        @(negedge clk);
        check("done_single", int'(done), 0);
        bus.m_ready_x = 1'b0;
        bus.m_ready_f = 1'b0;
    endtask

    task automatic reset_mid_send();
        int hs = 0;
        @(posedge clk); #1;
        start         = 1'b1;
        num_runs      = RUNW'(1);
        bus.m_ready_x = 1'b1;
        bus.m_ready_f = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && hs < 3; c++) begin
            @(negedge clk);
            if (bus.m_valid_x && bus.m_ready_x) hs++;
            @(posedge clk);
        end
        check("rst_reached_3rd", hs, 3);
        #1 reset = 1'b0;
        #1;
        check("rst_valid", int'({bus.m_valid_x, bus.m_valid_f}), 0);
        check("rst_busy_done", int'({busy, done}), 0);
        bus.m_ready_x = 1'b0;
        bus.m_ready_f = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NX; i++) mx[i] = '0;
        for (int i = 0; i < NF; i++) mf[i] = '0;
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_data", int'({bus.m_data_x, bus.m_data_f}), 0);
    endtask

    initial begin
        reset         = 1'b0;
        ld_en         = 1'b0;
        ld_sel        = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        start         = 1'b0;
        num_runs      = '0;
        bus.m_ready_x = 1'b0;
        bus.m_ready_f = 1'b0;
        for (int i = 0; i < NX; i++) mx[i] = '0;
        for (int i = 0; i < NF; i++) mf[i] = '0;

        @(negedge clk);
        check("reset_ctrl", int'({busy, done, bus.m_valid_x, bus.m_valid_f}), 0);
        check("reset_data", int'({bus.m_data_x, bus.m_data_f}), 0);
        #2 reset = 1'b1;

        begin
            int xv [NX] = '{10, -20, 30, -40, 50, 60, 70, 80};
            int fv [NF] = '{10, 20, -30, 40};
            for (int i = 0; i < NX; i++) load(SEL_X, i, xv[i]);
            for (int i = 0; i < NF; i++) load(SEL_F, i, fv[i]);
        end

        run_stream(1, 100, -1, 1'b0, 0);
        run_stream(2, 50, -1, 1'b0, 0);
        run_stream(0, 100, -1, 1'b0, 0);
        run_stream(1, 50, 2, 1'b0, 0);
        run_stream(1, 100, -1, 1'b0, 0);
        run_stream(1, 100, -1, 1'b1, -5);
        for (int k = 0; k < 3; k++) run_stream(int'($urandom_range(3, 1)), 70, -1, 1'b0, 0);
        reset_mid_send();
        run_stream(1, 100, -1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
